// File: rtl/axi4_slave_mem_responder_pkg.sv
// Shared types for the AXI4 slave memory responder.
//   burst_e  : AXI burst encodings (FIXED/INCR/WRAP/RSVD)
//   RESP_*   : AXI response codes
//   wstate_e : write-path FSM states
//   rstate_e : read-path FSM states
//   addr_lsb : byte-offset bits within one data word
package axi4_slave_mem_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}      wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_DATA, R_WAIT_LAST} rstate_e;

  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi4_slave_mem_responder_if.sv
// AXI4 bus bundle between the interconnect slave port and the responder.
//   slave  modport : the memory responder side
//   master modport : the interconnect / testbench side
interface axi4_slave_mem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid, awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast, wvalid, wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid, bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid, arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast, rvalid, rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid,                    output wready,
    output bid, bresp, bvalid,                             input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,  output arready,
    output rid, rdata, rresp, rlast, rvalid,               input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input  awready,
    output wdata, wstrb, wlast, wvalid,                    input  wready,
    input  bid, bresp, bvalid,                             output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,  input  arready,
    input  rid, rdata, rresp, rlast, rvalid,               output rready
  );
endinterface

// File: rtl/axi4_burst_addr_gen.sv
// Combinational AXI burst address step.
//   addr/len/size/burst : current beat address and burst attributes
//   next_addr           : address of the following beat
//   err                 : size wider than the bus or reserved burst type
module axi4_burst_addr_gen import axi4_slave_mem_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  err
);
  localparam int LSB = addr_lsb(DATA_WIDTH);

  logic [ADDR_WIDTH-1:0] step, incr, wrap_mask;
  logic                  wrap_ok;

  always_comb begin
    step      = ADDR_WIDTH'(1) << size;
    // INCR steps from the size-aligned address, so unaligned starts realign
    incr      = (addr & ~(step - ADDR_WIDTH'(1))) + step;
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    wrap_ok   = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    err       = (int'(size) > LSB) || (burst == BURST_RSVD);
    case (burst_e'(burst))
      BURST_FIXED: next_addr = addr;
      // illegal WRAP lengths fall back to INCR
      BURST_WRAP:  next_addr = wrap_ok ? ((addr & ~wrap_mask) | (incr & wrap_mask)) : incr;
      default:     next_addr = incr;
    endcase
  end
endmodule

// File: rtl/axi4_slave_mem_responder.sv
// AXI4 slave endpoint backed by a word memory.
//   aclk    : clock, rising edge
//   aresetn : asynchronous reset, active-high despite the name
//   s       : AXI4 slave bus (AW/W/B write path, AR/R read path)
// Read and write paths are independent; each carries one burst at a time.
module axi4_slave_mem_responder import axi4_slave_mem_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 256
) (
  input logic aclk,
  input logic aresetn,
  axi4_slave_mem_responder_if.slave s
);
  localparam int LSB    = addr_lsb(DATA_WIDTH);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * STRB_W);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // ---------------- write path ----------------
  wstate_e               w_state, w_next;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr, w_gen_addr;
  logic [7:0]            w_len, w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_err, w_gen_err, w_beat, w_last_beat, w_oor, w_beat_err;

  axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_wgen (
    .addr(w_addr), .len(w_len), .size(w_size), .burst(w_burst),
    .next_addr(w_gen_addr), .err(w_gen_err)
  );

  assign s.awready   = (w_state == W_IDLE);
  assign s.wready    = (w_state == W_DATA);
  assign s.bvalid    = (w_state == W_RESP);
  assign w_beat      = (w_state == W_DATA) && s.wvalid;
  assign w_last_beat = (w_cnt == w_len);
  assign w_oor       = (w_addr >= MEM_BYTES);
  // a wlast that disagrees with the beat count is flagged but does not end the burst
  assign w_beat_err  = w_oor || w_gen_err || (s.wlast != w_last_beat);

  always_ff @(posedge aclk or posedge aresetn)
    if (aresetn) w_state <= W_IDLE;
    else         w_state <= w_next;

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (s.awvalid)              w_next = W_DATA;
      W_DATA:  if (s.wvalid && w_last_beat) w_next = W_RESP;
      W_RESP:  if (s.bready)               w_next = W_IDLE;
      default:                             w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
      s.bid   <= '0;
      s.bresp <= RESP_OKAY;
    end else if (w_state == W_IDLE && s.awvalid) begin
      w_id    <= s.awid;
      w_addr  <= s.awaddr;
      w_len   <= s.awlen;
      w_size  <= s.awsize;
      w_burst <= s.awburst;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else if (w_beat) begin
      w_addr <= w_gen_addr;
      w_cnt  <= w_cnt + 8'd1;
      w_err  <= w_err | w_beat_err;
      if (w_last_beat) begin
        s.bid   <= w_id;
        s.bresp <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // storage is deliberately not reset
  always_ff @(posedge aclk)
    if (w_beat && !w_oor)
      for (int b = 0; b < STRB_W; b++)
        if (s.wstrb[b]) mem[w_addr[LSB +: IDX_W]][8*b +: 8] <= s.wdata[8*b +: 8];

  // ---------------- read path ----------------
  rstate_e               r_state, r_next;
  logic [ADDR_WIDTH-1:0] r_addr, r_gen_addr, r_fetch;
  logic [7:0]            r_len, r_cnt, g_len;
  logic [2:0]            r_size, g_size;
  logic [1:0]            r_burst, g_burst;
  logic                  r_gen_err, r_hs, r_load, r_oor;

  // while idle the generator only supplies the error flag for the incoming AR
  assign g_len   = (r_state == R_IDLE) ? s.arlen   : r_len;
  assign g_size  = (r_state == R_IDLE) ? s.arsize  : r_size;
  assign g_burst = (r_state == R_IDLE) ? s.arburst : r_burst;

  axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_rgen (
    .addr(r_addr), .len(g_len), .size(g_size), .burst(g_burst),
    .next_addr(r_gen_addr), .err(r_gen_err)
  );

  assign s.arready = (r_state == R_IDLE);
  assign s.rvalid  = (r_state != R_IDLE);
  assign s.rlast   = (r_state == R_WAIT_LAST);
  assign r_hs      = s.rvalid && s.rready;
  assign r_fetch   = (r_state == R_IDLE) ? s.araddr : r_gen_addr;
  assign r_oor     = (r_fetch >= MEM_BYTES);
  // a new beat is loaded only on AR accept or on a handshake of a non-final beat,
  // which keeps rdata/rresp stable under backpressure
  assign r_load    = ((r_state == R_IDLE) && s.arvalid) || ((r_state == R_DATA) && r_hs);

  always_ff @(posedge aclk or posedge aresetn)
    if (aresetn) r_state <= R_IDLE;
    else         r_state <= r_next;

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:      if (s.arvalid) r_next = (s.arlen == 8'd0) ? R_WAIT_LAST : R_DATA;
      R_DATA:      if (r_hs)      r_next = (r_cnt == r_len - 8'd1) ? R_WAIT_LAST : R_DATA;
      R_WAIT_LAST: if (r_hs)      r_next = R_IDLE;
      default:                    r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      s.rid   <= '0;
      s.rdata <= '0;
      s.rresp <= RESP_OKAY;
    end else if (r_load) begin
      r_addr  <= r_fetch;
      // same-cycle write to this word lands after this read: old data returned
      s.rdata <= r_oor ? '0 : mem[r_fetch[LSB +: IDX_W]];
      s.rresp <= (r_oor || r_gen_err) ? RESP_SLVERR : RESP_OKAY;
      if (r_state == R_IDLE) begin
        s.rid   <= s.arid;
        r_len   <= s.arlen;
        r_size  <= s.arsize;
        r_burst <= s.arburst;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_axi4_slave_mem_responder.sv
module tb_axi4_slave_mem_responder;
  localparam int AW = 32, DW = 64, IW = 4, DEPTH = 256;

  logic aclk = 1'b0;
  logic aresetn = 1'b1;
  always #5 aclk = ~aclk;

  axi4_slave_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  axi4_slave_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn), .s(bus)
  );

  int checks = 0, errors = 0;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rexp_t;
  rexp_t sb[$];

  typedef struct {
    bit          do_wr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [1:0]  burst;
    logic [2:0]  size;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [1:0]  exp_bresp;
    bit          do_rd;
    logic [31:0] rd_addr;
    logic [1:0]  rburst;
    logic [63:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } vec_t;
  vec_t vt [8];

  logic [63:0] wbuf [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_exp(input logic [63:0] d, input logic [1:0] r, input logic l, input logic [3:0] id);
    rexp_t e;
    e.data = d; e.resp = r; e.last = l; e.id = id;
    sb.push_back(e);
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size, input logic [7:0] strb,
                           input bit early_last, input int bp_cycles,
                           output logic [3:0] bid_o, output logic [1:0] bresp_o);
    int n;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awburst = burst; bus.awsize = size;
    bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 50) begin tick(); n++; end
    if (n >= 50) timeout("aw_handshake");
    tick();
    bus.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.wdata  = wbuf[i];
      bus.wstrb  = strb;
      bus.wlast  = early_last ? (i == 0) : (i == int'(len));
      bus.wvalid = 1'b1;
      n = 0;
      while (!bus.wready && n < 50) begin tick(); n++; end
      if (n >= 50) timeout("w_handshake");
      tick();
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 50) begin tick(); n++; end
    if (n >= 50) timeout("b_valid");
    for (int k = 0; k < bp_cycles; k++) begin
      chk("bp_bvalid", bus.bvalid, 1);
      chk("bp_bid", bus.bid, id);
      chk("bp_awready", bus.awready, 0);
      tick();
    end
    bus.bready = 1'b1;
    bid_o   = bus.bid;
    bresp_o = bus.bresp;
    tick();
    bus.bready = 1'b0;
    if (bp_cycles > 0) chk("b_then_awready", bus.awready, 1);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input bit timing_chk);
    int n, cyc, beats;
    bit done;
    rexp_t e;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arburst = burst; bus.arsize = size;
    bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 50) begin tick(); n++; end
    if (n >= 50) timeout("ar_handshake");
    tick();
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    cyc = 0; beats = 0; done = 1'b0;
    while (!done && cyc < 100) begin
      if (bus.rvalid) begin
        if (sb.size() == 0) timeout("sb_underflow");
        else begin
          e = sb.pop_front();
          chk($sformatf("rdata_b%0d", beats), bus.rdata, e.data);
          chk($sformatf("rresp_b%0d", beats), bus.rresp, e.resp);
          chk($sformatf("rlast_b%0d", beats), bus.rlast, e.last);
          chk($sformatf("rid_b%0d", beats), bus.rid, e.id);
        end
        if (timing_chk) chk($sformatf("beat_cycle_b%0d", beats), cyc, beats);
        done = bus.rlast;
        beats++;
      end
      tick();
      cyc++;
    end
    if (!done) timeout("r_burst");
    bus.rready = 1'b0;
    if (timing_chk) begin
      chk("arready_after_last", bus.arready, 1);
      chk("rvalid_after_last", bus.rvalid, 0);
    end
    chk("read_beats", beats, int'(len) + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] bid;
    logic [1:0] bresp;
    int n;

    //        wr    id     addr        bst   size  wdata                  strb    bresp  rd    rd_addr     rbst  rdata                  rresp
    vt[0] = '{1'b1, 4'd3, 32'h0000_0010, 2'd1, 3'd3, 64'h1122334455667788, 8'hFF, 2'd0, 1'b1, 32'h0000_0010, 2'd1, 64'h1122334455667788, 2'd0};
    vt[1] = '{1'b1, 4'd1, 32'h0000_0020, 2'd1, 3'd3, 64'h0,                8'hFF, 2'd0, 1'b1, 32'h0000_0020, 2'd1, 64'h0,                2'd0};
    vt[2] = '{1'b1, 4'd2, 32'h0000_0020, 2'd1, 3'd3, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 2'd0, 1'b1, 32'h0000_0020, 2'd1, 64'h00000000FFFFFFFF, 2'd0};
    vt[3] = '{1'b1, 4'd4, 32'h0000_0000, 2'd1, 3'd3, 64'hA5A5A5A5A5A5A5A5, 8'hFF, 2'd0, 1'b1, 32'h0000_0000, 2'd1, 64'hA5A5A5A5A5A5A5A5, 2'd0};
    vt[4] = '{1'b1, 4'd5, 32'h0000_0800, 2'd1, 3'd3, 64'hDEADBEEFCAFEF00D, 8'hFF, 2'd2, 1'b1, 32'h0000_0800, 2'd1, 64'h0,                2'd2};
    vt[5] = '{1'b0, 4'd6, 32'h0000_0000, 2'd1, 3'd3, 64'h0,                8'h00, 2'd0, 1'b1, 32'h0000_0000, 2'd1, 64'hA5A5A5A5A5A5A5A5, 2'd0};
    vt[6] = '{1'b1, 4'd6, 32'h0000_0030, 2'd1, 3'd4, 64'h0123456789ABCDEF, 8'hFF, 2'd2, 1'b0, 32'h0,          2'd1, 64'h0,                2'd0};
    vt[7] = '{1'b1, 4'd7, 32'h0000_0038, 2'd3, 3'd3, 64'h0F0F0F0F0F0F0F0F, 8'hFF, 2'd2, 1'b1, 32'h0000_0010, 2'd3, 64'h1122334455667788, 2'd2};

    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    repeat (3) tick();
    chk("rst_awready", bus.awready, 1);
    chk("rst_arready", bus.arready, 1);
    chk("rst_wready", bus.wready, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rlast", bus.rlast, 0);
    chk("rst_bresp", bus.bresp, 0);
    chk("rst_rresp", bus.rresp, 0);
    chk("rst_bid", bus.bid, 0);
    chk("rst_rid", bus.rid, 0);
    chk("rst_rdata", bus.rdata, 0);
    aresetn = 1'b0;
    tick();

    // single-beat vectors
    for (int i = 0; i < 8; i++) begin
      if (vt[i].do_wr) begin
        wbuf[0] = vt[i].wdata;
        axi_write(vt[i].id, vt[i].addr, 8'd0, vt[i].burst, vt[i].size, vt[i].wstrb, 1'b0, 0, bid, bresp);
        chk($sformatf("v%0d_bresp", i), bresp, vt[i].exp_bresp);
        chk($sformatf("v%0d_bid", i), bid, vt[i].id);
      end
      if (vt[i].do_rd) begin
        push_exp(vt[i].exp_rdata, vt[i].exp_rresp, 1'b1, vt[i].id);
        axi_read(vt[i].id, vt[i].rd_addr, 8'd0, vt[i].rburst, 3'd3, 1'b0);
      end
    end

    // INCR len=3 burst write then full-rate read
    for (int i = 0; i < 4; i++) wbuf[i] = 64'hC0DE_0000_0000_0000 | 64'(i + 1);
    axi_write(4'd8, 32'h100, 8'd3, 2'd1, 3'd3, 8'hFF, 1'b0, 0, bid, bresp);
    chk("incr_bresp", bresp, 0);
    chk("incr_bid", bid, 8);
    for (int i = 0; i < 4; i++) push_exp(64'hC0DE_0000_0000_0000 | 64'(i + 1), 2'd0, i == 3, 4'd9);
    axi_read(4'd9, 32'h100, 8'd3, 2'd1, 3'd3, 1'b1);

    // WRAP len=3 from 0x118: 0x118, 0x100, 0x108, 0x110
    push_exp(64'hC0DE_0000_0000_0004, 2'd0, 1'b0, 4'd10);
    push_exp(64'hC0DE_0000_0000_0001, 2'd0, 1'b0, 4'd10);
    push_exp(64'hC0DE_0000_0000_0002, 2'd0, 1'b0, 4'd10);
    push_exp(64'hC0DE_0000_0000_0003, 2'd0, 1'b1, 4'd10);
    axi_read(4'd10, 32'h118, 8'd3, 2'd2, 3'd3, 1'b0);

    // wlast on beat 0 of a 2-beat burst: both beats still taken, SLVERR
    wbuf[0] = 64'h1; wbuf[1] = 64'h2;
    axi_write(4'd11, 32'h40, 8'd1, 2'd1, 3'd3, 8'hFF, 1'b1, 0, bid, bresp);
    chk("early_wlast_bresp", bresp, 2);
    chk("early_wlast_bid", bid, 11);

    // B-channel backpressure for 5 cycles
    wbuf[0] = 64'h5555_AAAA_5555_AAAA;
    axi_write(4'd12, 32'h48, 8'd0, 2'd1, 3'd3, 8'hFF, 1'b0, 5, bid, bresp);
    chk("bp_bresp", bresp, 0);
    chk("bp_final_bid", bid, 12);
    chk("sb_drained", sb.size(), 0);

    // reset in the middle of an 8-beat read
    bus.arid = 4'd13; bus.araddr = 32'h100; bus.arlen = 8'd7; bus.arburst = 2'd1; bus.arsize = 3'd3;
    bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 50) begin tick(); n++; end
    if (n >= 50) timeout("rst_ar_handshake");
    tick();
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    tick();
    tick();
    bus.rready = 1'b0;
    chk("mid_rvalid_before_rst", bus.rvalid, 1);
    #2;
    aresetn = 1'b1;
    #1;
    chk("mid_rst_rvalid", bus.rvalid, 0);
    chk("mid_rst_rlast", bus.rlast, 0);
    chk("mid_rst_awready", bus.awready, 1);
    chk("mid_rst_arready", bus.arready, 1);
    tick();
    aresetn = 1'b0;
    tick();

    // storage survives reset
    push_exp(64'h1122334455667788, 2'd0, 1'b1, 4'd14);
    axi_read(4'd14, 32'h10, 8'd0, 2'd1, 3'd3, 1'b0);
    chk("sb_final", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
